// File: rtl/kbd_pkg.sv
// Shared scan-code constants, parser states and the queued key-event payload
// for the PS/2 key event decoder.
package kbd_pkg;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXTBRK
  } parse_state_e;

  typedef struct packed {
    logic [7:0] code;
    logic [7:0] ascii;
    logic       ext;
    logic       brk;
    logic [2:0] mods;
  } kbd_evt_t;

endpackage

// File: rtl/kbd_ascii_map.sv
// Scan-code set 2 to ASCII lookup. Letters always come out lowercase; the
// shift input only selects the upper symbol of digit and punctuation keys.
module kbd_ascii_map (
  input  logic [7:0] code,
  input  logic       shift,
  output logic [7:0] ascii_c
);

  always_comb begin
    ascii_c = 8'h00;
    case (code)
      8'h1C: ascii_c = 8'h61;
      8'h32: ascii_c = 8'h62;
      8'h21: ascii_c = 8'h63;
      8'h23: ascii_c = 8'h64;
      8'h24: ascii_c = 8'h65;
      8'h2B: ascii_c = 8'h66;
      8'h34: ascii_c = 8'h67;
      8'h33: ascii_c = 8'h68;
      8'h43: ascii_c = 8'h69;
      8'h3B: ascii_c = 8'h6A;
      8'h42: ascii_c = 8'h6B;
      8'h4B: ascii_c = 8'h6C;
      8'h3A: ascii_c = 8'h6D;
      8'h31: ascii_c = 8'h6E;
      8'h44: ascii_c = 8'h6F;
      8'h4D: ascii_c = 8'h70;
      8'h15: ascii_c = 8'h71;
      8'h2D: ascii_c = 8'h72;
      8'h1B: ascii_c = 8'h73;
      8'h2C: ascii_c = 8'h74;
      8'h3C: ascii_c = 8'h75;
      8'h2A: ascii_c = 8'h76;
      8'h1D: ascii_c = 8'h77;
      8'h22: ascii_c = 8'h78;
      8'h35: ascii_c = 8'h79;
      8'h1A: ascii_c = 8'h7A;
      8'h45: ascii_c = shift ? 8'h29 : 8'h30;
      8'h16: ascii_c = shift ? 8'h21 : 8'h31;
      8'h1E: ascii_c = shift ? 8'h40 : 8'h32;
      8'h26: ascii_c = shift ? 8'h23 : 8'h33;
      8'h25: ascii_c = shift ? 8'h24 : 8'h34;
      8'h2E: ascii_c = shift ? 8'h25 : 8'h35;
      8'h36: ascii_c = shift ? 8'h5E : 8'h36;
      8'h3D: ascii_c = shift ? 8'h26 : 8'h37;
      8'h3E: ascii_c = shift ? 8'h2A : 8'h38;
      8'h46: ascii_c = shift ? 8'h28 : 8'h39;
      8'h4E: ascii_c = shift ? 8'h5F : 8'h2D;
      8'h55: ascii_c = shift ? 8'h2B : 8'h3D;
      8'h54: ascii_c = shift ? 8'h7B : 8'h5B;
      8'h5B: ascii_c = shift ? 8'h7D : 8'h5D;
      8'h5D: ascii_c = shift ? 8'h7C : 8'h5C;
      8'h4C: ascii_c = shift ? 8'h3A : 8'h3B;
      8'h52: ascii_c = shift ? 8'h22 : 8'h27;
      8'h0E: ascii_c = shift ? 8'h7E : 8'h60;
      8'h41: ascii_c = shift ? 8'h3C : 8'h2C;
      8'h49: ascii_c = shift ? 8'h3E : 8'h2E;
      8'h4A: ascii_c = shift ? 8'h3F : 8'h2F;
      8'h29: ascii_c = 8'h20;
      8'h5A: ascii_c = 8'h0D;
      8'h66: ascii_c = 8'h08;
      8'h0D: ascii_c = 8'h09;
      8'h76: ascii_c = 8'h1B;
      default: ascii_c = 8'h00;
    endcase
  end

endmodule

// File: rtl/ps2_key_event_decoder.sv
// PS/2 scan byte parser with modifier tracking, ASCII translation and an
// event FIFO. Define KBD_CAPSLOCK_EN to enable the caps-lock toggle on 0x58.
module ps2_key_event_decoder
  import kbd_pkg::*;
#(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned REPORT_BREAK = 0,
  parameter int unsigned CNT_W        = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [7:0]       evt_code,
  output logic [7:0]       evt_ascii,
  output logic             evt_ext,
  output logic             evt_brk,
  output logic [2:0]       evt_mods,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  input  logic             ovf_clr
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  parse_state_e state;
  logic lshift, rshift, lctrl, rctrl, caps;
  logic key_c, key_ext_c, key_brk_c;
  logic is_lshift_c, is_rshift_c, is_lctrl_c, is_rctrl_c, is_caps_c, is_mod_c;
  logic lshift_n, rshift_n, lctrl_n, rctrl_n, caps_n, shift_eff, ctrl_eff;
  logic [7:0] base_ascii_c, ascii_c;
  logic is_letter_c, push_c, pop_c, full_c, push_ok_c, drop_c;
  kbd_evt_t evt_c, head;
  kbd_evt_t mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;

  // A byte completes a key unless it is a prefix accepted by the current state.
  always_comb begin
    key_c     = 1'b0;
    key_ext_c = 1'b0;
    key_brk_c = 1'b0;
    if (byte_valid) begin
      case (state)
        S_IDLE:   key_c = (byte_data != SC_EXT) && (byte_data != SC_BRK);
        S_EXT:    begin key_c = (byte_data != SC_BRK); key_ext_c = 1'b1; end
        S_BRK:    begin key_c = 1'b1; key_brk_c = 1'b1; end
        default:  begin key_c = 1'b1; key_ext_c = 1'b1; key_brk_c = 1'b1; end
      endcase
    end
  end

  assign is_lshift_c = key_c && !key_ext_c && (byte_data == SC_LSHIFT);
  assign is_rshift_c = key_c && !key_ext_c && (byte_data == SC_RSHIFT);
  assign is_lctrl_c  = key_c && !key_ext_c && (byte_data == SC_CTRL);
  assign is_rctrl_c  = key_c &&  key_ext_c && (byte_data == SC_CTRL);
`ifdef KBD_CAPSLOCK_EN
  assign is_caps_c   = key_c && !key_ext_c && (byte_data == SC_CAPS);
  assign caps_n      = (is_caps_c && !key_brk_c) ? ~caps : caps;
`else
  assign is_caps_c   = 1'b0;
  assign caps_n      = 1'b0;
`endif
  assign is_mod_c = is_lshift_c | is_rshift_c | is_lctrl_c | is_rctrl_c | is_caps_c;

  // Post-update modifier view so an event sees the effect of its own byte.
  assign lshift_n  = is_lshift_c ? !key_brk_c : lshift;
  assign rshift_n  = is_rshift_c ? !key_brk_c : rshift;
  assign lctrl_n   = is_lctrl_c  ? !key_brk_c : lctrl;
  assign rctrl_n   = is_rctrl_c  ? !key_brk_c : rctrl;
  assign shift_eff = lshift_n | rshift_n;
  assign ctrl_eff  = lctrl_n | rctrl_n;

  kbd_ascii_map u_map (
    .code    (byte_data),
    .shift   (shift_eff),
    .ascii_c (base_ascii_c)
  );

  assign is_letter_c = (base_ascii_c >= 8'h61) && (base_ascii_c <= 8'h7A);

  always_comb begin
    ascii_c = base_ascii_c;
    if (key_ext_c)                      ascii_c = 8'h00;
    else if (is_letter_c && ctrl_eff)   ascii_c = base_ascii_c - 8'h60;
    else if (is_letter_c && (shift_eff ^ caps_n)) ascii_c = base_ascii_c - 8'h20;
  end

  always_comb begin
    evt_c.code  = byte_data;
    evt_c.ascii = ascii_c;
    evt_c.ext   = key_ext_c;
    evt_c.brk   = key_brk_c;
    evt_c.mods  = {caps_n, ctrl_eff, shift_eff};
  end

  assign push_c    = key_c && !is_mod_c && (!key_brk_c || (REPORT_BREAK != 0));
  assign pop_c     = evt_valid && evt_ready;
  assign full_c    = (count == CNT_W'(DEPTH));
  assign push_ok_c = push_c && (!full_c || pop_c);
  assign drop_c    = push_c && !push_ok_c;

  // Parser state and modifier flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      lshift <= 1'b0;
      rshift <= 1'b0;
      lctrl  <= 1'b0;
      rctrl  <= 1'b0;
    end else if (byte_valid) begin
      case (state)
        S_IDLE: begin
          if (byte_data == SC_EXT)      state <= S_EXT;
          else if (byte_data == SC_BRK) state <= S_BRK;
        end
        S_EXT:   state <= (byte_data == SC_BRK) ? S_EXTBRK : S_IDLE;
        default: state <= S_IDLE;
      endcase
      lshift <= lshift_n;
      rshift <= rshift_n;
      lctrl  <= lctrl_n;
      rctrl  <= rctrl_n;
    end
  end

`ifdef KBD_CAPSLOCK_EN
  always_ff @(posedge clk) begin
    if (rst) caps <= 1'b0;
    else     caps <= caps_n;
  end
`else
  assign caps = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (push_ok_c) mem[wr_ptr] <= evt_c;
  end

  // FIFO pointers, occupancy and sticky overflow; a drop beats ovf_clr.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok_c, pop_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (drop_c)       overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  assign evt_valid = (count != '0);
  assign head      = evt_valid ? mem[rd_ptr] : '0;
  assign evt_code  = head.code;
  assign evt_ascii = head.ascii;
  assign evt_ext   = head.ext;
  assign evt_brk   = head.brk;
  assign evt_mods  = head.mods;

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Bench for ps2_key_event_decoder: two instances (break reporting off/on)
// share one byte stream and are checked against a queue-based key model.
module tb_ps2_key_event_decoder;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned CNT_W = 4;

  typedef struct packed {
    logic [7:0] code;
    logic [7:0] ascii;
    logic       ext;
    logic       brk;
    logic [2:0] mods;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, byte_valid = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic rdy0 = 1'b0, rdy1 = 1'b0, clr0 = 1'b0, clr1 = 1'b0;

  logic v0, v1, ext0, ext1, brk0, brk1, ovf0, ovf1;
  logic [7:0] code0, code1, asc0, asc1;
  logic [2:0] mods0, mods1;
  logic [CNT_W-1:0] cnt0, cnt1;

  ps2_key_event_decoder #(.DEPTH(DEPTH), .REPORT_BREAK(0)) dut0 (
    .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
    .evt_valid(v0), .evt_ready(rdy0), .evt_code(code0), .evt_ascii(asc0),
    .evt_ext(ext0), .evt_brk(brk0), .evt_mods(mods0), .count(cnt0),
    .overflow(ovf0), .ovf_clr(clr0));

  ps2_key_event_decoder #(.DEPTH(DEPTH), .REPORT_BREAK(1)) dut1 (
    .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
    .evt_valid(v1), .evt_ready(rdy1), .evt_code(code1), .evt_ascii(asc1),
    .evt_ext(ext1), .evt_brk(brk1), .evt_mods(mods1), .count(cnt1),
    .overflow(ovf1), .ovf_clr(clr1));

  int checks = 0;
  int errors = 0;

  // Reference model state
  ev_t m_q0[$], m_q1[$];
  bit  m_ovf0, m_ovf1, m_pend_ext, m_pend_brk;
  bit  m_lsh, m_rsh, m_lctl, m_rctl, m_caps;

  logic [7:0] letter_codes [26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,
    8'h3B,8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,8'h1B,8'h2C,8'h3C,8'h2A,8'h1D,
    8'h22,8'h35,8'h1A};
  logic [7:0] digit_codes [10] = '{8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46};
  logic [7:0] digit_sym   [10] = '{8'h29,8'h21,8'h40,8'h23,8'h24,8'h25,8'h5E,8'h26,8'h2A,8'h28};
  logic [7:0] oth_code [16] = '{8'h29,8'h5A,8'h66,8'h0D,8'h76,8'h4E,8'h55,8'h54,8'h5B,8'h5D,
    8'h4C,8'h52,8'h0E,8'h41,8'h49,8'h4A};
  logic [7:0] oth_norm [16] = '{8'h20,8'h0D,8'h08,8'h09,8'h1B,8'h2D,8'h3D,8'h5B,8'h5D,8'h5C,
    8'h3B,8'h27,8'h60,8'h2C,8'h2E,8'h2F};
  logic [7:0] oth_shft [16] = '{8'h20,8'h0D,8'h08,8'h09,8'h1B,8'h5F,8'h2B,8'h7B,8'h7D,8'h7C,
    8'h3A,8'h22,8'h7E,8'h3C,8'h3E,8'h3F};

  function automatic logic [7:0] model_ascii(input logic [7:0] c, input bit sh, input bit cp,
                                             input bit ct);
    for (int i = 0; i < 26; i++)
      if (letter_codes[i] == c) begin
        if (ct) return 8'(i + 1);
        return (sh ^ cp) ? 8'(8'h41 + i) : 8'(8'h61 + i);
      end
    for (int i = 0; i < 10; i++)
      if (digit_codes[i] == c) return sh ? digit_sym[i] : 8'(8'h30 + i);
    for (int i = 0; i < 16; i++)
      if (oth_code[i] == c) return sh ? oth_shft[i] : oth_norm[i];
    return 8'h00;
  endfunction

  task automatic model_reset();
    m_q0.delete(); m_q1.delete();
    m_ovf0 = 0; m_ovf1 = 0; m_pend_ext = 0; m_pend_brk = 0;
    m_lsh = 0; m_rsh = 0; m_lctl = 0; m_rctl = 0; m_caps = 0;
  endtask

  // Apply one received byte; got=1 when it completes a non-modifier key.
  task automatic model_byte(input logic [7:0] b, output bit got, output ev_t ev);
    bit e, br;
    got = 0; ev = '0;
    if (!m_pend_ext && !m_pend_brk && b == 8'hE0) begin m_pend_ext = 1; return; end
    if (!m_pend_brk && b == 8'hF0) begin m_pend_brk = 1; return; end
    e = m_pend_ext; br = m_pend_brk; m_pend_ext = 0; m_pend_brk = 0;
    if (b == 8'h12 && !e) begin m_lsh = !br; return; end
    if (b == 8'h59 && !e) begin m_rsh = !br; return; end
    if (b == 8'h14) begin if (e) m_rctl = !br; else m_lctl = !br; return; end
`ifdef KBD_CAPSLOCK_EN
    if (b == 8'h58 && !e) begin if (!br) m_caps = !m_caps; return; end
`endif
    got = 1;
    ev.code = b; ev.ext = e; ev.brk = br;
    ev.mods = {m_caps, m_lctl | m_rctl, m_lsh | m_rsh};
    ev.ascii = e ? 8'h00 : model_ascii(b, m_lsh | m_rsh, m_caps, m_lctl | m_rctl);
  endtask

  // Drive one cycle (called and returning at a falling edge) and advance the model.
  task automatic step(input bit bv, input logic [7:0] bd, input bit r0, input bit r1,
                      input bit c0, input bit c1, input bit rs);
    bit got; ev_t ev;
    rst = rs; byte_valid = bv; byte_data = bd; rdy0 = r0; rdy1 = r1; clr0 = c0; clr1 = c1;
    if (rs) model_reset();
    else begin
      if (r0 && m_q0.size() > 0) void'(m_q0.pop_front());
      if (r1 && m_q1.size() > 0) void'(m_q1.pop_front());
      if (c0) m_ovf0 = 0;
      if (c1) m_ovf1 = 0;
      got = 0; ev = '0;
      if (bv) model_byte(bd, got, ev);
      if (got && !ev.brk) begin
        if (m_q0.size() < DEPTH) m_q0.push_back(ev); else m_ovf0 = 1;
      end
      if (got) begin
        if (m_q1.size() < DEPTH) m_q1.push_back(ev); else m_ovf1 = 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b); step(1, b, 0, 0, 0, 0, 0); endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH + 2 && (v0 || v1); i++) step(0, 8'h00, 1, 1, 0, 0, 0);
  endtask

  task automatic test_reset();
    step(0, 8'h00, 1, 1, 1, 1, 1);
    step(0, 8'h00, 0, 0, 0, 0, 1);
    checks++;
    if ({v0, code0, asc0, ext0, brk0, mods0, cnt0, ovf0} !== '0) begin
      errors++; $display("FAIL reset_dut0 got %h exp 0", {v0, code0, asc0, ext0, brk0, mods0, cnt0, ovf0});
    end
    checks++;
    if ({v1, code1, asc1, ext1, brk1, mods1, cnt1, ovf1} !== '0) begin
      errors++; $display("FAIL reset_dut1 got %h exp 0", {v1, code1, asc1, ext1, brk1, mods1, cnt1, ovf1});
    end
    step(0, 8'h00, 0, 0, 0, 0, 0);
  endtask

  task automatic test_single_make();
    send(8'h1C);
    checks++;
    if ({v0, code0, asc0, ext0, brk0, mods0, cnt0} !== {1'b1, 8'h1C, 8'h61, 1'b0, 1'b0, 3'b000, 4'd1}) begin
      errors++; $display("FAIL single_make got %h exp %h", {v0, code0, asc0, ext0, brk0, mods0, cnt0},
                         {1'b1, 8'h1C, 8'h61, 1'b0, 1'b0, 3'b000, 4'd1});
    end
    drain();
  endtask

  task automatic test_shift();
    logic [7:0] seq [6] = '{8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12};
    foreach (seq[i]) send(seq[i]);
    checks++;
    if ({cnt0, code0, asc0, ext0, brk0, mods0} !== {4'd1, 8'h1C, 8'h41, 1'b0, 1'b0, 3'b001}) begin
      errors++; $display("FAIL shift_make got %h exp %h", {cnt0, code0, asc0, ext0, brk0, mods0},
                         {4'd1, 8'h1C, 8'h41, 1'b0, 1'b0, 3'b001});
    end
    checks++;
    if (cnt1 !== 4'd2) begin errors++; $display("FAIL shift_brk_count got %0d exp 2", cnt1); end
    drain();
    send(8'h1C);
    checks++;
    if ({asc0, mods0} !== {8'h61, 3'b000}) begin
      errors++; $display("FAIL shift_released got %h exp %h", {asc0, mods0}, {8'h61, 3'b000});
    end
    drain();
  endtask

  task automatic test_ctrl();
    logic [7:0] seq [5] = '{8'hE0, 8'h14, 8'hE0, 8'hF0, 8'h14};
    send(8'h14); send(8'h21);
    checks++;
    if ({code0, asc0, mods0} !== {8'h21, 8'h03, 3'b010}) begin
      errors++; $display("FAIL ctrl_letter got %h exp %h", {code0, asc0, mods0}, {8'h21, 8'h03, 3'b010});
    end
    send(8'hF0); send(8'h14);
    drain();
    foreach (seq[i]) send(seq[i]);
    checks++;
    if ({cnt0, cnt1} !== 8'h00) begin
      errors++; $display("FAIL rctrl_no_event got %h exp 00", {cnt0, cnt1});
    end
    send(8'h21);
    checks++;
    if ({asc0, mods0} !== {8'h63, 3'b000}) begin
      errors++; $display("FAIL ctrl_released got %h exp %h", {asc0, mods0}, {8'h63, 3'b000});
    end
    drain();
  endtask

  task automatic test_ext_break();
    logic [7:0] seq [5] = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75};
    foreach (seq[i]) send(seq[i]);
    checks++;
    if ({cnt0, cnt1} !== {4'd1, 4'd2}) begin
      errors++; $display("FAIL ext_counts got %h exp 12", {cnt0, cnt1});
    end
    checks++;
    if ({code1, asc1, ext1, brk1} !== {8'h75, 8'h00, 1'b1, 1'b0}) begin
      errors++; $display("FAIL ext_make got %h exp %h", {code1, asc1, ext1, brk1}, {8'h75, 8'h00, 2'b10});
    end
    step(0, 8'h00, 0, 1, 0, 0, 0);
    checks++;
    if ({code1, asc1, ext1, brk1} !== {8'h75, 8'h00, 1'b1, 1'b1}) begin
      errors++; $display("FAIL ext_break got %h exp %h", {code1, asc1, ext1, brk1}, {8'h75, 8'h00, 2'b11});
    end
    drain();
  endtask

  task automatic test_overflow();
    logic [7:0] keep [8] = '{8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h3B};
    for (int i = 0; i < 9; i++) send(letter_codes[i]);
    checks++;
    if ({cnt0, ovf0, code0} !== {4'd8, 1'b1, 8'h1C}) begin
      errors++; $display("FAIL ovf_full got %h exp %h", {cnt0, ovf0, code0}, {4'd8, 1'b1, 8'h1C});
    end
    step(1, 8'h3B, 1, 1, 0, 0, 0);
    checks++;
    if ({cnt0, ovf0} !== {4'd8, 1'b1}) begin
      errors++; $display("FAIL ovf_push_pop got %h exp %h", {cnt0, ovf0}, {4'd8, 1'b1});
    end
    step(0, 8'h00, 0, 0, 1, 1, 0);
    checks++;
    if ({ovf0, ovf1} !== 2'b00) begin errors++; $display("FAIL ovf_clr got %b exp 00", {ovf0, ovf1}); end
    foreach (keep[i]) begin
      checks++;
      if ({v0, code0} !== {1'b1, keep[i]}) begin
        errors++; $display("FAIL ovf_order%0d got %h exp %h", i, {v0, code0}, {1'b1, keep[i]});
      end
      step(0, 8'h00, 1, 1, 0, 0, 0);
    end
    checks++;
    if (cnt0 !== 4'd0) begin errors++; $display("FAIL ovf_drained got %0d exp 0", cnt0); end
  endtask

  task automatic test_caps();
`ifdef KBD_CAPSLOCK_EN
    send(8'h58); send(8'hF0); send(8'h58); send(8'h1C);
    checks++;
    if ({cnt0, asc0, mods0} !== {4'd1, 8'h41, 3'b100}) begin
      errors++; $display("FAIL caps_on got %h exp %h", {cnt0, asc0, mods0}, {4'd1, 8'h41, 3'b100});
    end
    drain();
    send(8'h12); send(8'h1C);
    checks++;
    if ({asc0, mods0} !== {8'h61, 3'b101}) begin
      errors++; $display("FAIL caps_shift got %h exp %h", {asc0, mods0}, {8'h61, 3'b101});
    end
    send(8'hF0); send(8'h12); send(8'h58); send(8'hF0); send(8'h58);
`else
    send(8'h58);
    checks++;
    if ({code0, asc0, mods0} !== {8'h58, 8'h00, 3'b000}) begin
      errors++; $display("FAIL caps_plain got %h exp %h", {code0, asc0, mods0}, {8'h58, 8'h00, 3'b000});
    end
`endif
    drain();
  endtask

  task automatic test_reset_midseq();
    send(8'hE0);
    step(0, 8'h00, 0, 0, 0, 0, 1);
    send(8'h1C);
    checks++;
    if ({code0, asc0, ext0, mods0} !== {8'h1C, 8'h61, 1'b0, 3'b000}) begin
      errors++; $display("FAIL reset_midseq got %h exp %h", {code0, asc0, ext0, mods0},
                         {8'h1C, 8'h61, 1'b0, 3'b000});
    end
    drain();
  endtask

  task automatic test_random();
    logic [7:0] pool [16] = '{8'h1C,8'h32,8'h21,8'h16,8'h45,8'h4E,8'h29,8'h5A,8'h12,8'h59,
                              8'h14,8'h58,8'h75,8'h05,8'h0E,8'h4A};
    logic [7:0] bq[$];
    logic [7:0] c;
    ev_t e0, e1;
    bit bv;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (bq.size() == 0) begin
        c = pool[$urandom_range(0, 15)];
        if ($urandom_range(0, 19) == 0) begin bq.push_back(8'hF0); bq.push_back(8'hE0); end
        else begin
          if (c != 8'h12 && c != 8'h59 && c != 8'h58 && $urandom_range(0, 3) == 0) bq.push_back(8'hE0);
          if ($urandom_range(0, 2) == 0) bq.push_back(8'hF0);
          bq.push_back(c);
        end
      end
      bv = ($urandom_range(0, 3) != 0) && (cyc < 2900);
      step(bv, bv ? bq.pop_front() : 8'h00, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0, 0);
      e0 = (m_q0.size() > 0) ? m_q0[0] : '0;
      e1 = (m_q1.size() > 0) ? m_q1[0] : '0;
      checks++;
      if ({v0, cnt0, ovf0, code0, asc0, ext0, brk0, mods0} !==
          {m_q0.size() != 0, CNT_W'(m_q0.size()), m_ovf0, e0}) begin
        errors++; $display("FAIL rand_dut0 cyc %0d got %h exp %h", cyc,
          {v0, cnt0, ovf0, code0, asc0, ext0, brk0, mods0}, {m_q0.size() != 0, CNT_W'(m_q0.size()), m_ovf0, e0});
      end
      checks++;
      if ({v1, cnt1, ovf1, code1, asc1, ext1, brk1, mods1} !==
          {m_q1.size() != 0, CNT_W'(m_q1.size()), m_ovf1, e1}) begin
        errors++; $display("FAIL rand_dut1 cyc %0d got %h exp %h", cyc,
          {v1, cnt1, ovf1, code1, asc1, ext1, brk1, mods1}, {m_q1.size() != 0, CNT_W'(m_q1.size()), m_ovf1, e1});
      end
    end
    drain();
    checks++;
    if ({v0, v1} !== 2'b00) begin errors++; $display("FAIL rand_drain got %b exp 00", {v0, v1}); end
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_single_make();
    test_shift();
    test_ctrl();
    test_ext_break();
    test_overflow();
    test_caps();
    test_reset_midseq();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
